// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
// The stage owns the request side; the memory answers with ack and read data.
interface memory_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
// Registers EX results, resolves branches, runs loads/stores over a variable
// latency req/ack bus with a timeout, and presents MEM/WB values to write-back.
module memory_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        Branch,
   input  logic        MemtoReg,
   input  logic        RegWrite,
   input  logic [31:0] add_result,
   input  logic [31:0] ALU_result,
   input  logic        Zero,
   input  logic [31:0] read_data_2,
   input  logic [4:0]  write_register_index,
   output logic        stall,
   output logic        PCSrc,
   output logic [31:0] branch_target,
   memory_stage_if.master mem,
   output logic        wb_valid,
   output logic        wb_RegWrite,
   output logic        wb_MemtoReg,
   output logic [31:0] wb_read_data,
   output logic [31:0] wb_ALU_result,
   output logic [4:0]  wb_write_register_index,
   output logic        mem_fault
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, next_state;
   logic [7:0]  timeout_count;

   // Instruction fields captured when an access starts, released at completion.
   logic        lat_mem_read;
   logic        lat_reg_write;
   logic        lat_mem_to_reg;
   logic [31:0] lat_alu_result;
   logic [4:0]  lat_index;

   // One-hot strobes describing what happens at the coming edge.
   logic        do_pass;
   logic        do_misalign;
   logic        do_start;
   logic        do_ack;
   logic        do_timeout;
   logic        mem_op;

   assign mem_op = MemRead | MemWrite;
   assign stall  = (state == BUSY);

   // State register.
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state decode and per-edge action strobes.
   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      next_state  = state;
      do_pass     = 1'b0;
      do_misalign = 1'b0;
      do_start    = 1'b0;
      do_ack      = 1'b0;
      do_timeout  = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               if (!mem_op) begin
                  do_pass = 1'b1;
               end else if (ALU_result[1:0] != 2'b00) begin
                  do_misalign = 1'b1;
               end else begin
                  do_start   = 1'b1;
                  next_state = BUSY;
               end
            end
         end
         BUSY: begin
            if (mem.mem_ack) begin
               do_ack     = 1'b1;
               next_state = IDLE;
            end else if (timeout_count == TIMEOUT_LAST) begin
               do_timeout = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Timeout counter: counts BUSY cycles without ack, cleared on any exit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timeout_count <= '0;
      end else if (state == BUSY && !do_ack && !do_timeout) begin
         timeout_count <= timeout_count + 8'd1;
      end else begin
         timeout_count <= '0;
      end
   end

   // Memory request side and the latched instruction for the access in flight.
   // NOTE: the latch registers are reset along with everything else; they are
   // a handful of flops, not a memory array, so the reset costs nothing.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem.mem_req    <= 1'b0;
         mem.mem_we     <= 1'b0;
         mem.mem_addr   <= '0;
         mem.mem_wdata  <= '0;
         lat_mem_read   <= 1'b0;
         lat_reg_write  <= 1'b0;
         lat_mem_to_reg <= 1'b0;
         lat_alu_result <= '0;
         lat_index      <= '0;
      end else if (do_start) begin
         mem.mem_req    <= 1'b1;
         mem.mem_we     <= MemWrite;
         mem.mem_addr   <= ALU_result;
         mem.mem_wdata  <= read_data_2;
         lat_mem_read   <= MemRead;
         lat_reg_write  <= RegWrite;
         lat_mem_to_reg <= MemtoReg;
         lat_alu_result <= ALU_result;
         lat_index      <= write_register_index;
      end else if (do_ack || do_timeout) begin
         mem.mem_req    <= 1'b0;
      end
   end

   // Write-back and branch outputs: pulses default low, data holds until updated.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wb_valid                <= 1'b0;
         wb_RegWrite             <= 1'b0;
         wb_MemtoReg             <= 1'b0;
         wb_read_data            <= '0;
         wb_ALU_result           <= '0;
         wb_write_register_index <= '0;
         PCSrc                   <= 1'b0;
         branch_target           <= '0;
         mem_fault               <= 1'b0;
      end else begin
         wb_valid  <= 1'b0;
         PCSrc     <= 1'b0;
         mem_fault <= 1'b0;
         if (do_pass) begin
            wb_valid                <= 1'b1;
            wb_RegWrite             <= RegWrite;
            wb_MemtoReg             <= MemtoReg;
            wb_read_data            <= '0;
            wb_ALU_result           <= ALU_result;
            wb_write_register_index <= write_register_index;
            PCSrc                   <= Branch & Zero;
            branch_target           <= add_result;
         end else if (do_misalign) begin
            wb_valid                <= 1'b1;
            wb_RegWrite             <= 1'b0;
            wb_MemtoReg             <= MemtoReg;
            wb_read_data            <= '0;
            wb_ALU_result           <= ALU_result;
            wb_write_register_index <= write_register_index;
            mem_fault               <= 1'b1;
         end else if (do_ack) begin
            wb_valid                <= 1'b1;
            wb_RegWrite             <= lat_reg_write;
            wb_MemtoReg             <= lat_mem_to_reg;
            wb_read_data            <= lat_mem_read ? mem.mem_rdata : 32'd0;
            wb_ALU_result           <= lat_alu_result;
            wb_write_register_index <= lat_index;
         end else if (do_timeout) begin
            wb_valid                <= 1'b1;
            wb_RegWrite             <= 1'b0;
            wb_MemtoReg             <= lat_mem_to_reg;
            wb_read_data            <= '0;
            wb_ALU_result           <= lat_alu_result;
            wb_write_register_index <= lat_index;
            mem_fault               <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized transactions against a
// transaction-level expectation of the stage.
module tb_memory_stage;

   localparam int TIMEOUT = 15;

   logic        clock;
   logic        reset_n;
   logic        in_valid, MemRead, MemWrite, Branch, MemtoReg, RegWrite, Zero;
   logic [31:0] add_result, ALU_result, read_data_2;
   logic [4:0]  write_register_index;
   logic        stall, PCSrc, wb_valid, wb_RegWrite, wb_MemtoReg, mem_fault;
   logic [31:0] branch_target, wb_read_data, wb_ALU_result;
   logic [4:0]  wb_write_register_index;

   int tests_run    = 0;
   int tests_failed = 0;

   memory_stage_if mem_bus ();

   memory_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock                   (clock),
      .reset_n                 (reset_n),
      .in_valid                (in_valid),
      .MemRead                 (MemRead),
      .MemWrite                (MemWrite),
      .Branch                  (Branch),
      .MemtoReg                (MemtoReg),
      .RegWrite                (RegWrite),
      .add_result              (add_result),
      .ALU_result              (ALU_result),
      .Zero                    (Zero),
      .read_data_2             (read_data_2),
      .write_register_index    (write_register_index),
      .stall                   (stall),
      .PCSrc                   (PCSrc),
      .branch_target           (branch_target),
      .mem                     (mem_bus.master),
      .wb_valid                (wb_valid),
      .wb_RegWrite             (wb_RegWrite),
      .wb_MemtoReg             (wb_MemtoReg),
      .wb_read_data            (wb_read_data),
      .wb_ALU_result           (wb_ALU_result),
      .wb_write_register_index (wb_write_register_index),
      .mem_fault               (mem_fault)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        in_valid;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        zero;
      logic        mem_to_reg;
      logic        reg_write;
      logic [31:0] add_result;
      logic [31:0] alu_result;
      logic [31:0] wdata;
      logic [4:0]  idx;
   } instr_t;

   typedef struct {
      instr_t      ins;
      logic        e_wb_valid;
      logic        e_reg_write;
      logic        e_fault;
      logic        e_pcsrc;
      logic [31:0] e_target;
      logic        chk_data;
      logic [31:0] e_alu;
      logic [4:0]  e_idx;
   } vec_t;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic checkb(input string name, input logic actual, input logic expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input instr_t ins);
      in_valid             = ins.in_valid;
      MemRead              = ins.mem_read;
      MemWrite             = ins.mem_write;
      Branch               = ins.branch;
      Zero                 = ins.zero;
      MemtoReg             = ins.mem_to_reg;
      RegWrite             = ins.reg_write;
      add_result           = ins.add_result;
      ALU_result           = ins.alu_result;
      read_data_2          = ins.wdata;
      write_register_index = ins.idx;
   endtask

   function automatic instr_t mk(input logic v, input logic rd, input logic wr, input logic br,
                                 input logic z, input logic m2r, input logic rw,
                                 input logic [31:0] tgt, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [4:0] idx);
      instr_t i;
      i.in_valid = v;   i.mem_read = rd;   i.mem_write = wr; i.branch = br;
      i.zero = z;       i.mem_to_reg = m2r; i.reg_write = rw;
      i.add_result = tgt; i.alu_result = alu; i.wdata = wd; i.idx = idx;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      instr_t i;
      int kind;
      kind = int'($urandom_range(0, 3));
      i.in_valid   = (kind != 3);
      i.mem_read   = (kind == 1);
      i.mem_write  = (kind == 2);
      i.branch     = 1'($urandom_range(0, 1));
      i.zero       = 1'($urandom_range(0, 1));
      i.mem_to_reg = 1'($urandom_range(0, 1));
      i.reg_write  = 1'($urandom_range(0, 1));
      i.add_result = $urandom;
      i.alu_result = $urandom;
      if ($urandom_range(0, 9) < 7) i.alu_result[1:0] = 2'b00;
      i.wdata      = $urandom;
      i.idx        = 5'($urandom_range(0, 31));
      return i;
   endfunction

   // Issue one instruction from IDLE and follow it to completion.
   // The memory acks on BUSY cycle number ack_delay (0 = same cycle req rises);
   // an ack that would come on or after cycle TIMEOUT never arrives in time.
   task automatic run_txn(input string tag, input instr_t ins, input int ack_delay,
                          input logic [31:0] rdata);
      logic mem_op, aligned, acked;
      int   n_busy;
      drive(ins);
      mem_bus.mem_ack   = 1'($urandom_range(0, 1));
      mem_bus.mem_rdata = $urandom;
      tick();
      mem_op  = ins.mem_read | ins.mem_write;
      aligned = (ins.alu_result[1:0] == 2'b00);
      if (!ins.in_valid) begin
         checkb({tag, " bubble wb_valid"}, wb_valid, 1'b0);
         checkb({tag, " bubble PCSrc"}, PCSrc, 1'b0);
         checkb({tag, " bubble mem_fault"}, mem_fault, 1'b0);
         checkb({tag, " bubble stall"}, stall, 1'b0);
         checkb({tag, " bubble mem_req"}, mem_bus.mem_req, 1'b0);
      end else if (!mem_op) begin
         checkb({tag, " alu wb_valid"}, wb_valid, 1'b1);
         checkb({tag, " alu wb_RegWrite"}, wb_RegWrite, ins.reg_write);
         checkb({tag, " alu wb_MemtoReg"}, wb_MemtoReg, ins.mem_to_reg);
         check({tag, " alu wb_ALU_result"}, wb_ALU_result, ins.alu_result);
         check({tag, " alu wb_index"}, 32'(wb_write_register_index), 32'(ins.idx));
         check({tag, " alu wb_read_data"}, wb_read_data, 32'd0);
         checkb({tag, " alu PCSrc"}, PCSrc, ins.branch & ins.zero);
         if (ins.branch & ins.zero) check({tag, " alu branch_target"}, branch_target, ins.add_result);
         checkb({tag, " alu stall"}, stall, 1'b0);
         checkb({tag, " alu mem_req"}, mem_bus.mem_req, 1'b0);
      end else if (!aligned) begin
         checkb({tag, " misalign wb_valid"}, wb_valid, 1'b1);
         checkb({tag, " misalign wb_RegWrite"}, wb_RegWrite, 1'b0);
         checkb({tag, " misalign mem_fault"}, mem_fault, 1'b1);
         checkb({tag, " misalign mem_req"}, mem_bus.mem_req, 1'b0);
         checkb({tag, " misalign PCSrc"}, PCSrc, 1'b0);
         checkb({tag, " misalign stall"}, stall, 1'b0);
      end else begin
         checkb({tag, " start mem_req"}, mem_bus.mem_req, 1'b1);
         checkb({tag, " start mem_we"}, mem_bus.mem_we, ins.mem_write);
         check({tag, " start mem_addr"}, mem_bus.mem_addr, ins.alu_result);
         check({tag, " start mem_wdata"}, mem_bus.mem_wdata, ins.wdata);
         checkb({tag, " start wb_valid"}, wb_valid, 1'b0);
         checkb({tag, " start PCSrc"}, PCSrc, 1'b0);
         acked  = (ack_delay < TIMEOUT);
         n_busy = acked ? ack_delay + 1 : TIMEOUT;
         for (int k = 0; k < n_busy; k++) begin
            drive(rand_instr());
            in_valid          = 1'b1;
            mem_bus.mem_ack   = (k == ack_delay);
            mem_bus.mem_rdata = (k == ack_delay) ? rdata : $urandom;
            checkb({tag, " busy stall"}, stall, 1'b1);
            checkb({tag, " busy mem_req"}, mem_bus.mem_req, 1'b1);
            check({tag, " busy mem_addr"}, mem_bus.mem_addr, ins.alu_result);
            check({tag, " busy mem_wdata"}, mem_bus.mem_wdata, ins.wdata);
            checkb({tag, " busy wb_valid"}, wb_valid, 1'b0);
            tick();
         end
         mem_bus.mem_ack = 1'b0;
         checkb({tag, " done mem_req"}, mem_bus.mem_req, 1'b0);
         checkb({tag, " done stall"}, stall, 1'b0);
         checkb({tag, " done wb_valid"}, wb_valid, 1'b1);
         checkb({tag, " done PCSrc"}, PCSrc, 1'b0);
         if (acked) begin
            checkb({tag, " done mem_fault"}, mem_fault, 1'b0);
            checkb({tag, " done wb_RegWrite"}, wb_RegWrite, ins.reg_write);
            checkb({tag, " done wb_MemtoReg"}, wb_MemtoReg, ins.mem_to_reg);
            check({tag, " done wb_read_data"}, wb_read_data, ins.mem_read ? rdata : 32'd0);
            check({tag, " done wb_ALU_result"}, wb_ALU_result, ins.alu_result);
            check({tag, " done wb_index"}, 32'(wb_write_register_index), 32'(ins.idx));
         end else begin
            checkb({tag, " timeout mem_fault"}, mem_fault, 1'b1);
            checkb({tag, " timeout wb_RegWrite"}, wb_RegWrite, 1'b0);
         end
      end
   endtask

   vec_t vecs[6];

   initial begin
      instr_t nop;
      nop = mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);

      // Single-cycle IDLE behaviour: {instruction, expected next-edge outputs}.
      vecs[0] = '{mk(1, 0, 0, 0, 0, 0, 1, 32'd0, 32'h2A, 32'd0, 5'd8),   1, 1, 0, 0, 32'd0,   1, 32'h2A, 5'd8};
      vecs[1] = '{mk(1, 0, 0, 1, 1, 0, 0, 32'd111, 32'd0, 32'd0, 5'd0),  1, 0, 0, 1, 32'd111, 0, 32'd0, 5'd0};
      vecs[2] = '{mk(1, 0, 0, 1, 0, 0, 0, 32'd222, 32'd5, 32'd0, 5'd0),  1, 0, 0, 0, 32'd0,   0, 32'd0, 5'd0};
      vecs[3] = '{mk(1, 1, 0, 1, 1, 1, 1, 32'd77, 32'h102, 32'd0, 5'd3), 1, 0, 1, 0, 32'd0,   0, 32'd0, 5'd0};
      vecs[4] = '{mk(1, 0, 1, 0, 0, 0, 0, 32'd0, 32'h7, 32'd9, 5'd0),    1, 0, 1, 0, 32'd0,   0, 32'd0, 5'd0};
      vecs[5] = '{mk(0, 0, 0, 1, 1, 0, 1, 32'd99, 32'h44, 32'd0, 5'd4),  0, 0, 0, 0, 32'd0,   0, 32'd0, 5'd0};

      reset_n = 1'b0;
      drive(nop);
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;
      #3;
      checkb("reset stall", stall, 1'b0);
      checkb("reset mem_req", mem_bus.mem_req, 1'b0);
      checkb("reset wb_valid", wb_valid, 1'b0);
      checkb("reset PCSrc", PCSrc, 1'b0);
      check("reset wb_ALU_result", wb_ALU_result, 32'd0);
      #14 reset_n = 1'b1;
      tick();

      // Directed single-cycle vectors.
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].ins);
         tick();
         checkb($sformatf("vec%0d wb_valid", i), wb_valid, vecs[i].e_wb_valid);
         checkb($sformatf("vec%0d mem_fault", i), mem_fault, vecs[i].e_fault);
         checkb($sformatf("vec%0d PCSrc", i), PCSrc, vecs[i].e_pcsrc);
         checkb($sformatf("vec%0d stall", i), stall, 1'b0);
         checkb($sformatf("vec%0d mem_req", i), mem_bus.mem_req, 1'b0);
         if (vecs[i].e_wb_valid)
            checkb($sformatf("vec%0d wb_RegWrite", i), wb_RegWrite, vecs[i].e_reg_write);
         if (vecs[i].e_pcsrc)
            check($sformatf("vec%0d branch_target", i), branch_target, vecs[i].e_target);
         if (vecs[i].chk_data) begin
            check($sformatf("vec%0d wb_ALU_result", i), wb_ALU_result, vecs[i].e_alu);
            check($sformatf("vec%0d wb_index", i), 32'(wb_write_register_index), 32'(vecs[i].e_idx));
         end
      end
      drive(nop);
      tick();
      checkb("PCSrc pulse ends", PCSrc, 1'b0);
      checkb("wb_valid pulse ends", wb_valid, 1'b0);

      // Load with three BUSY cycles, store acked as req rises, timeout boundaries.
      run_txn("load3", mk(1, 1, 0, 0, 0, 1, 1, 32'd0, 32'h100, 32'd0, 5'd9), 2, 32'hDEADBEEF);
      run_txn("store0", mk(1, 0, 1, 0, 0, 0, 0, 32'd0, 32'h04, 32'd333, 5'd0), 0, 32'h12345678);
      run_txn("ack_last", mk(1, 1, 0, 0, 0, 1, 1, 32'd0, 32'h40, 32'd0, 5'd2), TIMEOUT - 1, 32'hCAFEF00D);
      run_txn("timeout", mk(1, 1, 0, 0, 0, 1, 1, 32'd0, 32'h200, 32'd0, 5'd6), 1000, 32'd0);

      // An ack arriving after the abort is ignored.
      drive(nop);
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
      checkb("late ack wb_valid", wb_valid, 1'b0);
      checkb("late ack stall", stall, 1'b0);
      checkb("late ack mem_req", mem_bus.mem_req, 1'b0);

      // Reset asserted in the second BUSY cycle drops everything immediately.
      drive(mk(1, 1, 0, 0, 0, 1, 1, 32'd0, 32'h300, 32'd0, 5'd7));
      tick();
      drive(nop);
      checkb("rst seq busy1 stall", stall, 1'b1);
      tick();
      checkb("rst seq busy2 mem_req", mem_bus.mem_req, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      checkb("rst async mem_req", mem_bus.mem_req, 1'b0);
      checkb("rst async stall", stall, 1'b0);
      checkb("rst async wb_valid", wb_valid, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      mem_bus.mem_ack   = 1'b1;
      mem_bus.mem_rdata = 32'h55AA55AA;
      tick();
      mem_bus.mem_ack = 1'b0;
      checkb("post rst wb_valid", wb_valid, 1'b0);
      checkb("post rst stall", stall, 1'b0);
      checkb("post rst mem_req", mem_bus.mem_req, 1'b0);
      checkb("post rst mem_fault", mem_fault, 1'b0);

      // Randomized transactions with random memory latency.
      for (int n = 0; n < 80; n++) begin
         run_txn($sformatf("rnd%0d", n), rand_instr(), int'($urandom_range(0, 20)), $urandom);
      end
      drive(nop);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
